// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared phase types, coil pattern table and decode helper
package stepper_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  // Coil words {B-, B+, A-, A+} for phases 0..3, shared with the driver side
  localparam logic [3:0] PHASE_PATTERN [4] = '{4'b0101, 4'b0110, 4'b1010, 4'b1001};

  // Returns {valid, conflict, phase}; only the four table words are valid
  function automatic logic [3:0] pattern_to_phase(input logic [3:0] coil);
    logic   valid;
    logic   conflict;
    phase_t ph;
    conflict = (coil[1:0] == 2'b11) || (coil[3:2] == 2'b11);
    valid    = 1'b0;
    ph       = '0;
    for (int i = 0; i < 4; i++) begin
      if (coil == PHASE_PATTERN[i]) begin
        valid = 1'b1;
        ph    = phase_t'(i);
      end
    end
    return {valid, conflict, ph};
  endfunction

endpackage

// File: rtl/phase_filter.sv
// rtl/phase_filter.sv - 2-flop synchronizer and stability filter for the coil word
module phase_filter #(
  parameter int FILTER_CYCLES = 1000
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [3:0] coil_in,
  output logic [3:0] filt,
  output logic       filt_upd
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // cnt_next is the number of consecutive cycles sync2 has held its current value
  always_comb begin
    cnt_next = cnt;
    if (sync2 != cand) begin
      cnt_next = CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      filt     <= '0;
      filt_upd <= 1'b0;
    end else begin
      sync1    <= coil_in;
      sync2    <= sync1;
      cand     <= sync2;
      cnt      <= cnt_next;
      filt_upd <= 1'b0;
      if ((cnt_next == CNT_MAX) && (sync2 != filt)) begin
        filt     <= sync2;
        filt_upd <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stepper_phase_decoder.sv
// rtl/stepper_phase_decoder.sv - full-step coil sequence decoder: position, direction, period, errors
module stepper_phase_decoder #(
  parameter int POS_W         = 16,
  parameter int FILTER_CYCLES = 1000,
  parameter int PERIOD_W      = 24,
  parameter int ERR_W         = 8
) (
  input  logic                clk_100mhz,
  input  logic                rst,
  input  logic                en,
  input  logic                zero_pos,
  input  logic [3:0]          coil_in,
  output logic [POS_W-1:0]    position,
  output logic                step_valid,
  output logic                step_dir,
  output logic                skip_err,
  output logic [ERR_W-1:0]    err_count,
  output logic                coil_fault,
  output logic                tracking,
  output logic [1:0]          phase,
  output logic [PERIOD_W-1:0] period_cycles
);

  import stepper_pkg::*;

  logic [3:0]          filt;
  logic                filt_upd;
  logic [3:0]          dec;
  logic                p_valid;
  logic                p_conflict;
  phase_t              p;
  phase_t              delta;
  state_t              state;
  logic [PERIOD_W-1:0] since_ctr;

  phase_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .coil_in   (coil_in),
    .filt      (filt),
    .filt_upd  (filt_upd)
  );

  assign dec        = pattern_to_phase(filt);
  assign p_valid    = dec[3];
  assign p_conflict = dec[2];
  assign p          = dec[1:0];
  assign delta      = p - phase;
  assign tracking   = (state == TRACK);

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state         <= ACQUIRE;
      position      <= '0;
      step_valid    <= 1'b0;
      step_dir      <= 1'b0;
      skip_err      <= 1'b0;
      err_count     <= '0;
      coil_fault    <= 1'b0;
      phase         <= '0;
      period_cycles <= '0;
      since_ctr     <= '0;
    end else begin
      step_valid <= 1'b0;
      skip_err   <= 1'b0;
      if (p_conflict) begin
        coil_fault <= 1'b1;
        state      <= ACQUIRE;
        since_ctr  <= '0;
      end else if (state == ACQUIRE) begin
        since_ctr <= '0;
        if (en && p_valid) begin
          state <= TRACK;
          phase <= p;
        end
      end else if (!en) begin
        state     <= ACQUIRE;
        since_ctr <= '0;
      end else begin
        if (since_ctr != '1) begin
          since_ctr <= since_ctr + 1'b1;
        end
        // De-energized words never raise p_valid, so they fall through and hold state
        if (filt_upd && p_valid) begin
          phase <= p;
          case (delta)
            2'd1, 2'd3: begin
              step_valid    <= 1'b1;
              step_dir      <= (delta == 2'd1);
              position      <= (delta == 2'd1) ? position + 1'b1 : position - 1'b1;
              period_cycles <= (since_ctr == '1) ? since_ctr : since_ctr + 1'b1;
              since_ctr     <= '0;
            end
            2'd2: begin
              skip_err <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
      // Zero request overrides any step landing in the same cycle
      if (zero_pos) begin
        position <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb/tb_stepper_phase_decoder.sv - self-checking bench for stepper_phase_decoder
module tb_stepper_phase_decoder;

  localparam int FC = 4;

  logic        clk_100mhz = 1'b0;
  logic        rst;
  logic        en;
  logic        zero_pos;
  logic [3:0]  coil_in;
  logic [15:0] position;
  logic        step_valid;
  logic        step_dir;
  logic        skip_err;
  logic [7:0]  err_count;
  logic        coil_fault;
  logic        tracking;
  logic [1:0]  phase;
  logic [23:0] period_cycles;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] m_pos;
  int          m_err;
  bit          m_dir;
  bit          m_fault;
  bit          m_track;
  int          m_q;
  logic [3:0]  m_filt;
  int          m_period;
  int          last_edge;

  stepper_phase_decoder #(
    .POS_W(16), .FILTER_CYCLES(FC), .PERIOD_W(24), .ERR_W(8)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .en           (en),
    .zero_pos     (zero_pos),
    .coil_in      (coil_in),
    .position     (position),
    .step_valid   (step_valid),
    .step_dir     (step_dir),
    .skip_err     (skip_err),
    .err_count    (err_count),
    .coil_fault   (coil_fault),
    .tracking     (tracking),
    .phase        (phase),
    .period_cycles(period_cycles)
  );

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Phase 0..3 walks (A,B) through 11, 01, 00, 10
  function automatic logic [3:0] pat_of(input int ph);
    bit a;
    bit b;
    a = (ph == 0) || (ph == 3);
    b = (ph == 0) || (ph == 1);
    return {~b, b, ~a, a};
  endfunction

  function automatic void decode(input logic [3:0] pat, output bit conflict, output bit valid,
                                 output int ph);
    conflict = (pat[1:0] == 2'b11) || (pat[3:2] == 2'b11);
    valid    = (pat[0] ^ pat[1]) && (pat[2] ^ pat[3]);
    if (pat[0] && pat[2])       ph = 0;
    else if (!pat[0] && pat[2]) ph = 1;
    else if (!pat[0])           ph = 2;
    else                        ph = 3;
  endfunction

  task automatic model_reset();
    m_pos = '0; m_err = 0; m_dir = 0; m_fault = 0; m_track = 0;
    m_q = 0; m_filt = 4'b0000; m_period = 0; last_edge = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_position"}, position, m_pos);
    chk({tag, "_step_dir"}, step_dir, m_dir);
    chk({tag, "_err_count"}, err_count, m_err);
    chk({tag, "_coil_fault"}, coil_fault, m_fault);
    chk({tag, "_tracking"}, tracking, m_track);
    chk({tag, "_phase"}, phase, m_q);
    chk({tag, "_period"}, period_cycles, m_period);
    chk({tag, "_quiet"}, {step_valid, skip_err}, 2'b00);
  endtask

  // Drive a pattern, hold it, and check pulse timing plus settled state
  task automatic apply(input string tag, input logic [3:0] pat, input int hold, input bit zero_on_step);
    bit exp_step, exp_skip, exp_acq, conflict, valid;
    int p, d;
    exp_step = 0; exp_skip = 0; exp_acq = 0;
    coil_in = pat;
    if (pat != m_filt) begin
      decode(pat, conflict, valid, p);
      m_filt = pat;
      if (conflict) begin
        m_fault = 1; m_track = 0;
      end else if (!m_track) begin
        if (valid) begin exp_acq = 1; m_track = 1; m_q = p; end
      end else if (valid) begin
        d = (p - m_q + 4) % 4;
        m_q = p;
        if (d == 1)      begin exp_step = 1; m_pos = m_pos + 16'd1; m_dir = 1; end
        else if (d == 3) begin exp_step = 1; m_pos = m_pos - 16'd1; m_dir = 0; end
        else if (d == 2) begin exp_skip = 1; if (m_err < 255) m_err++; end
        if (exp_step && zero_on_step) m_pos = '0;
      end
    end
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk_100mhz);
      if (k == 6) chk({tag, "_early"}, {step_valid, skip_err}, 2'b00);
      if (k == 7) begin
        chk({tag, "_step_valid"}, step_valid, exp_step);
        chk({tag, "_skip_err"}, skip_err, exp_skip);
        if (exp_step) begin m_period = cyc - last_edge; last_edge = cyc; end
        if (exp_acq) last_edge = cyc;
      end
      if (k == 8) check_state(tag);
      if (zero_on_step && k == 6) zero_pos = 1'b1;
      if (k == 7) zero_pos = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] pat;
    int r;
    rst = 1'b1; en = 1'b0; zero_pos = 1'b0; coil_in = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk_100mhz);
    check_state("reset");
    rst = 1'b0; en = 1'b1;

    // Forward sequence 0,1,2,3,0 with 20-cycle holds
    for (int i = 0; i < 5; i++) apply("fwd", pat_of(i % 4), 20, 0);
    chk("t1_position", position, 16'd4);
    chk("t1_period", period_cycles, 24'd20);
    chk("t1_tracking", tracking, 1'b1);

    // Zero, then reverse steps across zero
    zero_pos = 1'b1; @(negedge clk_100mhz); zero_pos = 1'b0; m_pos = '0;
    chk("zero_alone", position, 16'd0);
    apply("rev1", pat_of(3), 15, 0);
    chk("t2_wrap", position, 16'hFFFF);
    apply("rev2", pat_of(2), 15, 0);
    chk("t2_wrap2", position, 16'hFFFE);

    // Short glitch toward the next phase must be rejected
    r = 0;
    coil_in = pat_of(3);
    for (int k = 0; k < FC - 1; k++) begin @(negedge clk_100mhz); r += step_valid + skip_err; end
    coil_in = pat_of(2);
    for (int k = 0; k < 12; k++) begin @(negedge clk_100mhz); r += step_valid + skip_err; end
    chk("glitch_pulses", r, 0);
    check_state("glitch");

    // Two-phase jump, then a normal step
    apply("skip", pat_of(0), 15, 0);
    chk("t4_err", err_count, 8'd1);
    apply("after_skip", pat_of(1), 15, 0);

    // Disable then re-enable: position retained, re-acquire without a step
    en = 1'b0; @(negedge clk_100mhz); m_track = 0;
    check_state("en_off");
    en = 1'b1; @(negedge clk_100mhz); m_track = 1; last_edge = cyc;
    check_state("en_on");
    apply("post_en", pat_of(2), 15, 0);

    // Coil conflict on pair A, then recovery
    pat = pat_of(m_q);
    apply("conflict", {pat[3:2], 2'b11}, 15, 0);
    chk("t5_tracking", tracking, 1'b0);
    apply("recover", pat, 15, 0);
    chk("t5_fault_sticky", coil_fault, 1'b1);

    // Position 5, then a forward step coinciding with zero_pos
    zero_pos = 1'b1; @(negedge clk_100mhz); zero_pos = 1'b0; m_pos = '0;
    for (int i = 0; i < 5; i++) apply("to5", pat_of((m_q + 1) % 4), 10, 0);
    chk("t6_pos5", position, 16'd5);
    apply("zero_step", pat_of((m_q + 1) % 4), 10, 1);
    chk("t6_zero_wins", position, 16'd0);

    // Randomized walk including de-energized words
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0 && m_track) begin
        pat = pat_of(m_q);
        if ($urandom_range(0, 1) == 0) pat[1:0] = 2'b00; else pat[3:2] = 2'b00;
      end else begin
        pat = pat_of((m_q + $urandom_range(0, 3)) % 4);
      end
      apply("rand", pat, $urandom_range(9, 25), 0);
    end

    // Reset while a step is in flight: no pulse, all outputs cleared
    pat = pat_of((m_q + 1) % 4);
    coil_in = pat;
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b1; @(negedge clk_100mhz);
    model_reset();
    check_state("mid_reset");
    rst = 1'b0;
    apply("post_reset", pat, 15, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
